// File: rtl/aes_cipher_iter_if.sv
// aes_cipher_iter_if: block/key input and ciphertext output valid/ready channels of aes_cipher_iter.
// The master side is the host that provides the blocks and accepts the ciphertext.
interface aes_cipher_iter_if #(
   parameter int Nk = 4
);
   logic [0:127]      inputText;
   logic [0:32*Nk-1]  inputKey;
   logic              inValid;
   logic              inReady;
   logic [0:127]      outputText;
   logic              outValid;
   logic              outReady;
   modport master (
      output inputText, inputKey, inValid, outReady,
      input  inReady, outputText, outValid
   );
   modport slave (
      input  inputText, inputKey, inValid, outReady,
      output inReady, outputText, outValid
   );
endinterface

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryptor, one round per clock, round keys derived combinationally.
// Optional CIPHER_BACK2BACK_EN: a new block may enter on the same edge the previous ciphertext leaves.
module aes_cipher_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   aes_cipher_iter_if.slave bus
);
   localparam int NW = 4 * (Nr + 1);
   localparam logic [3:0] LAST = 4'(Nr);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   localparam logic [0:10][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

   state_t           state_q;
   logic [3:0]       round_q;
   logic             in_rdy_q;
   logic             out_vld_q;
   logic [0:127]     out_q;
   logic [0:127]     txt_q;
   logic [0:127]     st_q;
   logic [0:32*Nk-1] key_q;
   logic [0:31]      w [NW];
   logic [0:127]     rk;
   logic             accept;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:31] sub_word(input logic [0:31] x);
      return {SBOX[x[0:7]], SBOX[x[8:15]], SBOX[x[16:23]], SBOX[x[24:31]]};
   endfunction

   // Byte i of the state is row i%4, column i/4; mix=0 gives the final round.
   function automatic logic [0:127] rnd(input logic [0:127] s, input logic [0:127] k, input logic mix);
      logic [0:127] t, m;
      logic [7:0]   a0, a1, a2, a3;
      for (int i = 0; i < 16; i++)
         t[8*i +: 8] = SBOX[s[8*(i%4 + 4*((i/4 + i%4) % 4)) +: 8]];
      for (int c = 0; c < 4; c++) begin
         a0 = t[32*c +: 8];
         a1 = t[32*c+8 +: 8];
         a2 = t[32*c+16 +: 8];
         a3 = t[32*c+24 +: 8];
         m[32*c +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                          a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return (mix ? m : t) ^ k;
   endfunction

   always_comb begin
      logic [0:31] t;
      t = '0;
      w = '{default: '0};
      for (int i = 0; i < Nk; i++)
         w[i] = key_q[32*i +: 32];
      for (int i = Nk; i < NW; i++) begin
         t = w[i-1];
         if (i % Nk == 0)
            t = sub_word({t[8:31], t[0:7]}) ^ {RCON[4'(i/Nk)], 24'h0};
         else if (Nk > 6 && i % Nk == 4)
            t = sub_word(t);
         w[i] = w[i-Nk] ^ t;
      end
   end

   assign rk = {w[{round_q, 2'd0}], w[{round_q, 2'd1}], w[{round_q, 2'd2}], w[{round_q, 2'd3}]};

`ifdef CIPHER_BACK2BACK_EN
   assign bus.inReady = in_rdy_q || (state_q == DONE && bus.outReady);
`else
   assign bus.inReady = in_rdy_q;
`endif
   assign accept         = bus.inValid && bus.inReady;
   assign bus.outValid   = out_vld_q;
   assign bus.outputText = out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         round_q   <= '0;
         in_rdy_q  <= 1'b0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
         txt_q     <= '0;
         st_q      <= '0;
         key_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               in_rdy_q <= !accept;
               if (accept) begin
                  key_q   <= bus.inputKey;
                  txt_q   <= bus.inputText;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               st_q    <= txt_q ^ rk;
               round_q <= 4'd1;
               state_q <= ROUND;
            end
            ROUND: begin
               if (round_q != LAST) begin
                  st_q    <= rnd(st_q, rk, 1'b1);
                  round_q <= round_q + 4'd1;
               end else begin
                  out_q     <= rnd(st_q, rk, 1'b0);
                  out_vld_q <= 1'b1;
                  round_q   <= '0;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (bus.outReady) begin
                  out_vld_q <= 1'b0;
                  in_rdy_q  <= 1'b1;
                  state_q   <= IDLE;
`ifdef CIPHER_BACK2BACK_EN
                  if (bus.inValid) begin
                     key_q    <= bus.inputKey;
                     txt_q    <= bus.inputText;
                     in_rdy_q <= 1'b0;
                     state_q  <= LOAD;
                  end
`endif
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: scoreboard bench for AES-128/192/256 instances of aes_cipher_iter,
// covering reset, latency, backpressure, mid-operation reset and streaming spacing.
module tb_aes_cipher_iter;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] K192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef CIPHER_BACK2BACK_EN
   localparam int SP = 12;
`else
   localparam int SP = 13;
`endif

   typedef struct packed {
      logic [127:0] ct;
      int           acc;
      int           lat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb0[$], sb1[$], sb2[$];
   int   outs0[$];

   aes_cipher_iter_if #(.Nk(4)) b128();
   aes_cipher_iter_if #(.Nk(6)) b192();
   aes_cipher_iter_if #(.Nk(8)) b256();

   aes_cipher_iter #(.Nk(4), .Nr(10)) d128 (.clk(clk), .rst_n(rst_n), .bus(b128.slave));
   aes_cipher_iter #(.Nk(6), .Nr(12)) d192 (.clk(clk), .rst_n(rst_n), .bus(b192.slave));
   aes_cipher_iter #(.Nk(8), .Nr(14)) d256 (.clk(clk), .rst_n(rst_n), .bus(b256.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic int qsize(input int id);
      return id == 0 ? sb0.size() : id == 1 ? sb1.size() : sb2.size();
   endfunction

   function automatic logic rdy(input int id);
      return id == 0 ? b128.inReady : id == 1 ? b192.inReady : b256.inReady;
   endfunction

   task automatic set_valid(input int id, input logic v);
      case (id)
         0:       b128.inValid = v;
         1:       b192.inValid = v;
         default: b256.inValid = v;
      endcase
   endtask

   // Called just after a rising edge; returns after the accepting edge.
   task automatic send(input int id, input logic [255:0] k, input logic [127:0] ct, input int lat, output int acc);
      int   n;
      exp_t e;
      case (id)
         0:       begin b128.inputKey = k[127:0]; b128.inputText = PT; end
         1:       begin b192.inputKey = k[191:0]; b192.inputText = PT; end
         default: begin b256.inputKey = k;        b256.inputText = PT; end
      endcase
      set_valid(id, 1'b1);
      n = 0;
      @(negedge clk);
      while (!rdy(id) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 128'(rdy(id)), 128'(1));
      acc = cyc;
      e = '{ct: ct, acc: cyc, lat: lat};
      if (rdy(id))
         case (id)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
         endcase
      @(posedge clk);
      #1;
      set_valid(id, 1'b0);
   endtask

   task automatic wait_empty(input int id);
      int n;
      n = 0;
      while (qsize(id) != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", 128'(qsize(id) == 0), 128'(1));
   endtask

   task automatic on_out(input int id, input logic [127:0] ot);
      exp_t e;
      int   sz;
      sz = qsize(id);
      chk("sb_nonempty", 128'(sz != 0), 128'(1));
      if (sz != 0) begin
         case (id)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
         endcase
         chk("ciphertext", ot, e.ct);
         if (e.lat != 0) chk("latency", 128'(cyc - e.acc), 128'(e.lat));
      end
      if (id == 0) outs0.push_back(cyc);
   endtask

   always @(negedge clk) begin
      if (b128.outValid && b128.outReady) on_out(0, b128.outputText);
      if (b192.outValid && b192.outReady) on_out(1, b192.outputText);
      if (b256.outValid && b256.outReady) on_out(2, b256.outputText);
   end

   initial begin
      int acc, xfer, n;
      clk = 1'b0;
      rst_n = 1'b1;
      b128.inValid = 1'b0; b128.outReady = 1'b1; b128.inputText = '0; b128.inputKey = '0;
      b192.inValid = 1'b0; b192.outReady = 1'b1; b192.inputText = '0; b192.inputKey = '0;
      b256.inValid = 1'b0; b256.outReady = 1'b1; b256.inputText = '0; b256.inputKey = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 128'(b128.inReady), 128'(0));
      chk("rst_out_valid", 128'(b128.outValid), 128'(0));
      chk("rst_out_text", b128.outputText, 128'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // AES-128/192/256 known answers
      send(0, 256'(K128), CT128, 12, acc);
      wait_empty(0);
      @(negedge clk);
      chk("ov_one_cycle", 128'(b128.outValid), 128'(0));
      chk("idle_ready", 128'(b128.inReady), 128'(1));
      @(posedge clk);
      #1;
      send(1, 256'(K192), CT192, 14, acc);
      wait_empty(1);
      send(2, K256, CT256, 16, acc);
      wait_empty(2);
      // Backpressure with busy-time input noise
      b128.outReady = 1'b0;
      send(0, 256'(K128), CT128, 0, acc);
      n = 0;
      while (!b128.outValid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 128'(b128.outValid), 128'(1));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         b128.inValid = ~b128.inValid;
         b128.inputText = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("bp_text", b128.outputText, CT128);
         chk("bp_valid", 128'(b128.outValid), 128'(1));
         chk("bp_in_ready", 128'(b128.inReady), 128'(0));
      end
      @(posedge clk);
      #1;
      b128.inValid = 1'b0;
      b128.outReady = 1'b1;
      wait_empty(0);
      xfer = outs0[$];
      send(0, 256'(K128), CT128, 12, acc);
      chk("bp_order", 128'(acc > xfer), 128'(1));
      wait_empty(0);
      // Reset during round 5
      send(0, 256'(K128), CT128, 12, acc);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 128'(b128.outValid), 128'(0));
      chk("mid_rst_ready", 128'(b128.inReady), 128'(0));
      chk("mid_rst_text", b128.outputText, 128'(0));
      sb0.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(0, 256'(K128), CT128, 12, acc);
      wait_empty(0);
      // Streaming spacing
      outs0.delete();
      for (int i = 0; i < 3; i++) send(0, 256'(K128), CT128, 12, acc);
      n = 0;
      while (outs0.size() < 3 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("stream_count", 128'(outs0.size()), 128'(3));
      if (outs0.size() == 3) begin
         chk("spacing_1", 128'(outs0[1] - outs0[0]), 128'(SP));
         chk("spacing_2", 128'(outs0[2] - outs0[1]), 128'(SP));
      end
      repeat (5) @(negedge clk);
      chk("final_sb0_empty", 128'(sb0.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
